rv_barrier_ctrl: RTL and testbench

//  Owns the core's barrier resource: collects warp arrivals per barrier ID and holds arrived

---
 rtl/rv_barrier_ctrl_pkg.sv | 23 ++
 rtl/rv_barrier_slot.sv | 80 ++++++++
 rtl/rv_barrier_ctrl.sv | 91 +++++++++
 tb/tb_rv_barrier_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_barrier_ctrl_pkg.sv
// Shared sizing, slot state encoding and the lowest-index select used by the barrier controller.
package rv_barrier_ctrl_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_COLLECT = 2'd1,
        SLOT_PEND    = 2'd2
    } slot_state_e;

    // Index of the lowest set bit; 0 when the vector is empty (callers qualify with |vec).
    function automatic logic [NB_BITS-1:0] lowest_set_idx(input logic [NUM_BARRIERS-1:0] vec);
        lowest_set_idx = '0;
        for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set_idx = NB_BITS'(i);
        end
    endfunction

endpackage

// File: rtl/rv_barrier_slot.sv
// One barrier ID: collects arriving warps until the latched count is met, then waits for release.
module rv_barrier_slot
    import rv_barrier_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arrive,
    input  logic [NW_BITS-1:0]   arrive_wid,
    input  logic [NW_BITS-1:0]   arrive_size_m1,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    input  logic                 release_grant,
    output slot_state_e          state,
    output logic [NUM_WARPS-1:0] mask,
    output logic                 size_mismatch
);

    localparam logic [NW_BITS:0] CNT_ONE = (NW_BITS + 1)'(1);

    logic [NW_BITS:0]     count_q;
    logic [NW_BITS-1:0]   size_q;
    logic [NUM_WARPS-1:0] wid_onehot;
    logic [NUM_WARPS-1:0] flush_onehot;
    logic                 flush_hit;
    logic [NUM_WARPS-1:0] flush_mask;
    logic [NW_BITS:0]     flush_count;
    logic [NW_BITS:0]     join_count;
    logic [NW_BITS:0]     target;

    assign wid_onehot   = NUM_WARPS'(1) << arrive_wid;
    assign flush_onehot = NUM_WARPS'(1) << flush_wid;
    // Flush only touches a collecting slot that actually holds the warp.
    assign flush_hit    = flush_valid && (state == SLOT_COLLECT) && ((mask & flush_onehot) != '0);
    assign flush_mask   = flush_hit ? (mask & ~flush_onehot) : mask;
    assign flush_count  = flush_hit ? (count_q - CNT_ONE) : count_q;
    assign join_count   = flush_count + CNT_ONE;
    assign target       = {1'b0, size_q} + CNT_ONE;
    assign size_mismatch = arrive && (state == SLOT_COLLECT) && (arrive_size_m1 != size_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SLOT_IDLE;
            mask    <= '0;
            count_q <= '0;
            size_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                SLOT_IDLE: begin
                    if (arrive) begin
                        mask    <= wid_onehot;
                        count_q <= CNT_ONE;
                        size_q  <= arrive_size_m1;
                        state   <= (arrive_size_m1 == '0) ? SLOT_PEND : SLOT_COLLECT;
                    end
                end
                SLOT_COLLECT: begin
                    if (arrive) begin
                        mask    <= flush_mask | wid_onehot;
                        count_q <= join_count;
                        if (join_count == target) state <= SLOT_PEND;
                    end else if (flush_hit) begin
                        mask    <= flush_mask;
                        count_q <= flush_count;
                        if (flush_count == '0) state <= SLOT_IDLE;
                    end
                end
                SLOT_PEND: begin
                    if (release_grant) begin
                        state   <= SLOT_IDLE;
                        mask    <= '0;
                        count_q <= '0;
                    end
                end
                default: state <= SLOT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rv_barrier_ctrl.sv
// Barrier controller: per-ID slots, duplicate filtering, one release per cycle, sticky errors.
module rv_barrier_ctrl
    import rv_barrier_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_req_valid,
    output logic                 bar_req_ready,
    input  logic [NW_BITS-1:0]   bar_req_wid,
    input  logic [NB_BITS-1:0]   bar_req_id,
    input  logic [NW_BITS-1:0]   bar_req_size_m1,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    output logic [NUM_WARPS-1:0] bar_stall_mask,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 err_dup,
    output logic                 err_size,
    output logic                 busy
);

    slot_state_e             slot_state [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    slot_mask  [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] pend_vec;
    logic [NUM_BARRIERS-1:0] arrive_vec;
    logic [NUM_BARRIERS-1:0] grant_vec;
    logic [NUM_BARRIERS-1:0] size_mismatch_vec;
    logic [NB_BITS-1:0]      grant_idx;
    logic                    req_accept;
    logic                    req_dup;
    logic                    req_flushed;
    logic                    req_apply;

    always_comb begin
        // NOTE: defaults first so no path through the loop can infer a latch.
        bar_stall_mask = '0;
        busy           = 1'b0;
        pend_vec       = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            bar_stall_mask = bar_stall_mask | slot_mask[i];
            busy           = busy | (slot_state[i] != SLOT_IDLE);
            pend_vec[i]    = (slot_state[i] == SLOT_PEND);
        end
    end

    assign bar_req_ready = (slot_state[bar_req_id] != SLOT_PEND);
    assign req_accept    = bar_req_valid && bar_req_ready;
    assign req_dup       = bar_stall_mask[bar_req_wid];
    // A same-warp flush kills the arrival outright.
    assign req_flushed   = flush_valid && (flush_wid == bar_req_wid);
    assign req_apply     = req_accept && !req_dup && !req_flushed;
    assign arrive_vec    = req_apply ? (NUM_BARRIERS'(1) << bar_req_id) : '0;
    assign grant_idx     = lowest_set_idx(pend_vec);
    assign grant_vec     = pend_vec & (NUM_BARRIERS'(1) << grant_idx);

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        rv_barrier_slot u_slot (
            .clk            (clk),
            .reset          (reset),
            .arrive         (arrive_vec[g]),
            .arrive_wid     (bar_req_wid),
            .arrive_size_m1 (bar_req_size_m1),
            .flush_valid    (flush_valid),
            .flush_wid      (flush_wid),
            .release_grant  (grant_vec[g]),
            .state          (slot_state[g]),
            .mask           (slot_mask[g]),
            .size_mismatch  (size_mismatch_vec[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            release_valid <= 1'b0;
            release_id    <= '0;
            release_mask  <= '0;
            err_dup       <= 1'b0;
            err_size      <= 1'b0;
        end else begin
            release_valid <= |pend_vec;
            if (|pend_vec) begin
                release_id   <= grant_idx;
                release_mask <= slot_mask[grant_idx];
            end
            err_dup  <= err_dup | (req_accept && req_dup && !req_flushed);
            err_size <= err_size | (|size_mismatch_vec);
        end
    end

endmodule

// File: tb/tb_rv_barrier_ctrl.sv
// Directed bench for rv_barrier_ctrl; expected releases queue up as stimulus is driven.
module tb_rv_barrier_ctrl;
    import rv_barrier_ctrl_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 bar_req_valid;
    logic                 bar_req_ready;
    logic [NW_BITS-1:0]   bar_req_wid;
    logic [NB_BITS-1:0]   bar_req_id;
    logic [NW_BITS-1:0]   bar_req_size_m1;
    logic                 flush_valid;
    logic [NW_BITS-1:0]   flush_wid;
    logic [NUM_WARPS-1:0] bar_stall_mask;
    logic                 release_valid;
    logic [NB_BITS-1:0]   release_id;
    logic [NUM_WARPS-1:0] release_mask;
    logic                 err_dup;
    logic                 err_size;
    logic                 busy;

    typedef struct packed {
        logic [NB_BITS-1:0]   id;
        logic [NUM_WARPS-1:0] mask;
    } rel_t;

    rel_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    rv_barrier_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .bar_req_valid   (bar_req_valid),
        .bar_req_ready   (bar_req_ready),
        .bar_req_wid     (bar_req_wid),
        .bar_req_id      (bar_req_id),
        .bar_req_size_m1 (bar_req_size_m1),
        .flush_valid     (flush_valid),
        .flush_wid       (flush_wid),
        .bar_stall_mask  (bar_stall_mask),
        .release_valid   (release_valid),
        .release_id      (release_id),
        .release_mask    (release_mask),
        .err_dup         (err_dup),
        .err_size        (err_size),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_release(input int id, input int mask);
        exp_q.push_back(rel_t'{NB_BITS'(id), NUM_WARPS'(mask)});
    endtask

    task automatic arrive(input int wid, input int id, input int sm1);
        bar_req_valid   = 1'b1;
        bar_req_wid     = NW_BITS'(wid);
        bar_req_id      = NB_BITS'(id);
        bar_req_size_m1 = NW_BITS'(sm1);
        @(negedge clk);
        bar_req_valid   = 1'b0;
    endtask

    task automatic flush(input int wid);
        flush_valid = 1'b1;
        flush_wid   = NW_BITS'(wid);
        @(negedge clk);
        flush_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every release pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && release_valid) begin
            if (exp_q.size() == 0) begin
                check("release_with_empty_queue", 32'(release_valid), 32'd0);
            end else begin
                rel_t e;
                e = exp_q.pop_front();
                check("release_id", 32'(release_id), 32'(e.id));
                check("release_mask", 32'(release_mask), 32'(e.mask));
            end
        end
    end

    initial begin
        reset           = 1'b0;
        bar_req_valid   = 1'b0;
        bar_req_wid     = '0;
        bar_req_id      = '0;
        bar_req_size_m1 = '0;
        flush_valid     = 1'b0;
        flush_wid       = '0;
        #12;
        check("rst_stall", 32'(bar_stall_mask), 32'd0);
        check("rst_rel_valid", 32'(release_valid), 32'd0);
        check("rst_rel_id", 32'(release_id), 32'd0);
        check("rst_rel_mask", 32'(release_mask), 32'd0);
        check("rst_err_dup", 32'(err_dup), 32'd0);
        check("rst_err_size", 32'(err_size), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bar_req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Warps 0,2,3 gather on barrier 1 (size 3)
        arrive(0, 1, 2);
        check("t1_stall_a", 32'(bar_stall_mask), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        arrive(2, 1, 2);
        check("t1_stall_b", 32'(bar_stall_mask), 32'b0101);
        expect_release(1, 4'b1101);
        arrive(3, 1, 2);
        check("t1_stall_c", 32'(bar_stall_mask), 32'b1101);
        check("t1_ready_pend", 32'(bar_req_ready), 32'd0);
        check("t1_no_rel_yet", 32'(release_valid), 32'd0);
        tick(1);
        check("t1_rel_valid", 32'(release_valid), 32'd1);
        check("t1_stall_clear", 32'(bar_stall_mask), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        tick(1);
        check("t1_pulse_end", 32'(release_valid), 32'd0);
        check("t1_id_hold", 32'(release_id), 32'd1);
        check("t1_mask_hold", 32'(release_mask), 32'b1101);

        // Single-warp barrier goes straight to PEND
        expect_release(0, 4'b0100);
        arrive(2, 0, 0);
        check("t2_ready_pend", 32'(bar_req_ready), 32'd0);
        check("t2_no_rel_yet", 32'(release_valid), 32'd0);
        check("t2_stall", 32'(bar_stall_mask), 32'b0100);
        tick(1);
        check("t2_rel_valid", 32'(release_valid), 32'd1);
        check("t2_ready_back", 32'(bar_req_ready), 32'd1);
        tick(1);

        // Releases in order; arrival to a PEND barrier waits for ready
        arrive(1, 3, 1);
        expect_release(0, 4'b0001);
        expect_release(3, 4'b0110);
        expect_release(3, 4'b0001);
        arrive(0, 0, 0);
        arrive(2, 3, 1);
        check("t3_rel0_valid", 32'(release_valid), 32'd1);
        check("t3_stall", 32'(bar_stall_mask), 32'b0110);
        bar_req_valid   = 1'b1;
        bar_req_wid     = 2'd0;
        bar_req_id      = 2'd3;
        bar_req_size_m1 = 2'd0;
        #1;
        check("t3_ready_low", 32'(bar_req_ready), 32'd0);
        @(negedge clk);
        check("t3_rel3_valid", 32'(release_valid), 32'd1);
        check("t3_ready_high", 32'(bar_req_ready), 32'd1);
        check("t3_held_not_taken", 32'(bar_stall_mask), 32'd0);
        @(negedge clk);
        bar_req_valid = 1'b0;
        check("t3_held_taken", 32'(bar_stall_mask), 32'b0001);
        check("t3_gap", 32'(release_valid), 32'd0);
        tick(1);
        check("t3_rel_held", 32'(release_valid), 32'd1);
        tick(1);

        // Flush drains barrier 2 without releasing it
        arrive(0, 2, 3);
        arrive(1, 2, 3);
        check("t4_stall_two", 32'(bar_stall_mask), 32'b0011);
        flush(1);
        check("t4_stall_one", 32'(bar_stall_mask), 32'b0001);
        check("t4_busy", 32'(busy), 32'd1);
        flush(0);
        check("t4_stall_none", 32'(bar_stall_mask), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        tick(1);
        check("t4_no_release", 32'(release_valid), 32'd0);

        // Duplicate arrival and size disagreement
        arrive(1, 0, 1);
        arrive(1, 2, 0);
        check("t5_err_dup", 32'(err_dup), 32'd1);
        check("t5_err_size_clear", 32'(err_size), 32'd0);
        check("t5_dup_dropped", 32'(bar_stall_mask), 32'b0010);
        tick(1);
        check("t5_no_release", 32'(release_valid), 32'd0);
        expect_release(0, 4'b1010);
        arrive(3, 0, 2);
        check("t5_err_size", 32'(err_size), 32'd1);
        check("t5_stall", 32'(bar_stall_mask), 32'b1010);
        tick(1);
        check("t5_rel_valid", 32'(release_valid), 32'd1);
        tick(1);

        // Flush and arrival in the same cycle
        arrive(0, 1, 1);
        flush_valid = 1'b1;
        flush_wid   = 2'd2;
        arrive(2, 1, 1);
        flush_valid = 1'b0;
        check("t6_flush_wins", 32'(bar_stall_mask), 32'b0001);
        flush_valid = 1'b1;
        flush_wid   = 2'd0;
        arrive(3, 1, 1);
        flush_valid = 1'b0;
        check("t6_both_apply", 32'(bar_stall_mask), 32'b1000);
        expect_release(1, 4'b1100);
        arrive(2, 1, 1);
        check("t6_pend", 32'(bar_stall_mask), 32'b1100);
        tick(2);

        // Asynchronous reset mid-collect
        arrive(0, 1, 3);
        check("t7_collect", 32'(bar_stall_mask), 32'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("t7_stall", 32'(bar_stall_mask), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_err_dup", 32'(err_dup), 32'd0);
        check("t7_err_size", 32'(err_size), 32'd0);
        check("t7_rel_id", 32'(release_id), 32'd0);
        check("t7_rel_mask", 32'(release_mask), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_release(1, 4'b0100);
        arrive(2, 1, 0);
        check("t7_fresh", 32'(bar_stall_mask), 32'b0100);
        tick(1);
        check("t7_rel_valid", 32'(release_valid), 32'd1);
        tick(2);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
